// File: rtl/riscv_trap_redirect.sv
// ---------------------------------------------------------------------------
// riscv_trap_redirect
//
// Machine-level trap entry/exit sequencer. A trap request accepted in IDLE
// captures mepc/mcause and the trap target PC. The target is direct or
// vectored, taken from the mtvec fields sampled at acceptance. The next
// cycle issues a one-shot CSR write strobe. The block then holds a redirect
// request to instruction fetch until fetch accepts it.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_mtvec_mode/base       mtvec.MODE / mtvec.BASE from the CSR block
//   i_trap_valid/o_trap_ready   trap request handshake
//   i_trap_interrupt, i_trap_cause, i_trap_pc   trap description
//   o_csr_write, o_mepc, o_mcause   one-cycle CSR update strobe and values
//   o_redirect_valid/i_redirect_ready, o_redirect_pc   fetch redirect
//   o_busy                  sequencer not in IDLE
//
// Optional feature macro: RISCV_TRAP_REDIRECT_MRET_EN
//   Adds i_mret_valid and i_mepc. An mret in IDLE redirects fetch to mepc
//   without a CSR write. A simultaneous trap takes priority.
// ---------------------------------------------------------------------------
module riscv_trap_redirect #(
   parameter int XLEN        = 32,
   parameter int CAUSE_WIDTH = 5
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [1:0]             i_mtvec_mode,
   input  logic [XLEN-3:0]        i_mtvec_base,
   input  logic                   i_trap_valid,
   output logic                   o_trap_ready,
   input  logic                   i_trap_interrupt,
   input  logic [CAUSE_WIDTH-1:0] i_trap_cause,
   input  logic [XLEN-1:0]        i_trap_pc,
`ifdef RISCV_TRAP_REDIRECT_MRET_EN
   input  logic                   i_mret_valid,
   input  logic [XLEN-1:0]        i_mepc,
`endif
   output logic                   o_csr_write,
   output logic [XLEN-1:0]        o_mepc,
   output logic [XLEN-1:0]        o_mcause,
   output logic                   o_redirect_valid,
   input  logic                   i_redirect_ready,
   output logic [XLEN-1:0]        o_redirect_pc,
   output logic                   o_busy
);

   typedef enum logic [1:0] {
      IDLE,
      ENTRY,
      REDIRECT
   } state_t;

   state_t          state_q;
   logic            csrWrite_q;
   logic [XLEN-1:0] mepc_q;
   logic [XLEN-1:0] mcause_q;
   logic            redirectValid_q;
   logic [XLEN-1:0] redirectPc_q;
   logic            busy_q;

   logic [XLEN-1:0] causeExt;
   logic [XLEN-1:0] vectorBase;
   logic [XLEN-1:0] target_d;
   logic [XLEN-1:0] mepc_d;
   logic [XLEN-1:0] mcause_d;
   logic            unusedBits;

   // The trap values are computed straight from the live inputs. They are
   // captured on the accepting edge, so later mtvec changes cannot affect a
   // trap that is already in flight. Only vectored mode with an interrupt
   // adds the cause offset; reserved modes behave as direct. The sum wraps
   // silently at 2^XLEN.
   assign causeExt   = {{(XLEN-CAUSE_WIDTH){1'b0}}, i_trap_cause};
   assign vectorBase = {i_mtvec_base, 2'b00};
   assign target_d   = (i_mtvec_mode == 2'b01 && i_trap_interrupt) ?
                       vectorBase + (causeExt << 2) : vectorBase;
   assign mepc_d     = {i_trap_pc[XLEN-1:2], 2'b00};
   assign mcause_d   = {i_trap_interrupt, {(XLEN-1-CAUSE_WIDTH){1'b0}}, i_trap_cause};

`ifdef RISCV_TRAP_REDIRECT_MRET_EN
   assign unusedBits = ^{i_trap_pc[1:0], i_mepc[1:0]};
`else
   assign unusedBits = ^i_trap_pc[1:0];
`endif

   // The ready indication comes from the state rather than a register, so a
   // trap offered in the first cycle after reset release is accepted. It is
   // gated by reset so that nothing appears accepted while reset is held.
   assign o_trap_ready = (state_q == IDLE) && i_rst_n;

   // Sequencer FSM with registered outputs. ENTRY lasts exactly one cycle
   // and carries the CSR strobe. REDIRECT holds valid until fetch accepts.
   // While the block is busy, trap requests are not sampled at all.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q         <= IDLE;
         csrWrite_q      <= 1'b0;
         mepc_q          <= '0;
         mcause_q        <= '0;
         redirectValid_q <= 1'b0;
         redirectPc_q    <= '0;
         busy_q          <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_trap_valid) begin
                  mepc_q       <= mepc_d;
                  mcause_q     <= mcause_d;
                  redirectPc_q <= target_d;
                  csrWrite_q   <= 1'b1;
                  busy_q       <= 1'b1;
                  state_q      <= ENTRY;
               end
`ifdef RISCV_TRAP_REDIRECT_MRET_EN
               else if (i_mret_valid) begin
                  redirectPc_q    <= {i_mepc[XLEN-1:2], 2'b00};
                  redirectValid_q <= 1'b1;
                  busy_q          <= 1'b1;
                  state_q         <= REDIRECT;
               end
`endif
            end
            ENTRY: begin
               csrWrite_q      <= 1'b0;
               redirectValid_q <= 1'b1;
               state_q         <= REDIRECT;
            end
            REDIRECT: begin
               if (i_redirect_ready) begin
                  redirectValid_q <= 1'b0;
                  busy_q          <= 1'b0;
                  state_q         <= IDLE;
               end
            end
            default: begin
               csrWrite_q      <= 1'b0;
               redirectValid_q <= 1'b0;
               busy_q          <= 1'b0;
               state_q         <= IDLE;
            end
         endcase
      end
   end

   assign o_csr_write      = csrWrite_q;
   assign o_mepc           = mepc_q;
   assign o_mcause         = mcause_q;
   assign o_redirect_valid = redirectValid_q;
   assign o_redirect_pc    = redirectPc_q;
   assign o_busy           = busy_q;

endmodule

// File: tb/tb_riscv_trap_redirect.sv
// ---------------------------------------------------------------------------
// tb_riscv_trap_redirect
//
// Self-checking bench for riscv_trap_redirect. Expected CSR and redirect
// values are pushed to a queue when a trap is driven. They are popped and
// compared when the DUT raises its CSR strobe. Inputs are driven and outputs
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_riscv_trap_redirect;

   typedef struct {
      logic [31:0] mepc;
      logic [31:0] mcause;
      logic [31:0] target;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstN;
   logic [1:0]  mtvecMode;
   logic [29:0] mtvecBase;
   logic        trapValid;
   logic        trapReady;
   logic        trapInterrupt;
   logic [4:0]  trapCause;
   logic [31:0] trapPc;
   logic        csrWrite;
   logic [31:0] mepc;
   logic [31:0] mcause;
   logic        redirectValid;
   logic        redirectReady;
   logic [31:0] redirectPc;
   logic        busy;
`ifdef RISCV_TRAP_REDIRECT_MRET_EN
   logic        mretValid;
   logic [31:0] mepcIn;
`endif

   int   checkCount = 0;
   int   errorCount = 0;
   exp_t expQ[$];

   // Trap case table: inputs alongside hand-computed expected results.
   logic [1:0]  caseMode   [7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd2, 2'd1};
   logic [29:0] caseBase   [7] = '{30'h100, 30'h100, 30'h100, 30'h3FFF_FFFF,
                                   30'h3FFF_FFFF, 30'h12345, 30'h12345};
   logic        caseIntr   [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [4:0]  caseCause  [7] = '{5'd2, 5'd7, 5'd7, 5'd1, 5'd1, 5'd31, 5'd31};
   logic [31:0] casePc     [7] = '{32'h8000_0040, 32'h1000_0003, 32'h2000_0006,
                                   32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0ABC,
                                   32'h7FFF_FFFD};
   logic [31:0] caseMepc   [7] = '{32'h8000_0040, 32'h1000_0000, 32'h2000_0004,
                                   32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0ABC,
                                   32'h7FFF_FFFC};
   logic [31:0] caseMcause [7] = '{32'h0000_0002, 32'h8000_0007, 32'h0000_0007,
                                   32'h8000_0001, 32'h8000_0001, 32'h8000_001F,
                                   32'h8000_001F};
   logic [31:0] caseTarget [7] = '{32'h0000_0400, 32'h0000_041C, 32'h0000_0400,
                                   32'h0000_0000, 32'hFFFF_FFFC, 32'h0004_8D14,
                                   32'h0004_8D90};

   riscv_trap_redirect #(.XLEN(32), .CAUSE_WIDTH(5)) dut (
      .i_clk            (clk),
      .i_rst_n          (rstN),
      .i_mtvec_mode     (mtvecMode),
      .i_mtvec_base     (mtvecBase),
      .i_trap_valid     (trapValid),
      .o_trap_ready     (trapReady),
      .i_trap_interrupt (trapInterrupt),
      .i_trap_cause     (trapCause),
      .i_trap_pc        (trapPc),
`ifdef RISCV_TRAP_REDIRECT_MRET_EN
      .i_mret_valid     (mretValid),
      .i_mepc           (mepcIn),
`endif
      .o_csr_write      (csrWrite),
      .o_mepc           (mepc),
      .o_mcause         (mcause),
      .o_redirect_valid (redirectValid),
      .i_redirect_ready (redirectReady),
      .o_redirect_pc    (redirectPc),
      .o_busy           (busy)
   );

   always #5 clk = ~clk;

   // Drives one trap request for the current cycle and records what the DUT
   // must later report for it.
   task automatic applyStimulus(input logic [1:0] mode, input logic [29:0] base,
                                input logic intr, input logic [4:0] cause,
                                input logic [31:0] pc, input logic [31:0] eMepc,
                                input logic [31:0] eMcause, input logic [31:0] eTarget);
      exp_t e;
      mtvecMode     = mode;
      mtvecBase     = base;
      trapInterrupt = intr;
      trapCause     = cause;
      trapPc        = pc;
      trapValid     = 1'b1;
      e.mepc        = eMepc;
      e.mcause      = eMcause;
      e.target      = eTarget;
      expQ.push_back(e);
   endtask

   task automatic test_reset;
      rstN          = 1'b0;
      trapValid     = 1'b0;
      redirectReady = 1'b1;
      mtvecMode     = 2'd0;
      mtvecBase     = '0;
      trapInterrupt = 1'b0;
      trapCause     = '0;
      trapPc        = '0;
`ifdef RISCV_TRAP_REDIRECT_MRET_EN
      mretValid     = 1'b0;
      mepcIn        = '0;
`endif
      repeat (3) @(negedge clk);
      checkCount++;
      if ({csrWrite, redirectValid, busy} !== 3'b000) begin
         errorCount++;
         $display("[TB] FAIL reset_flags got %b exp 000", {csrWrite, redirectValid, busy});
      end
      checkCount++;
      if ({mepc, mcause, redirectPc} !== 96'd0) begin
         errorCount++;
         $display("[TB] FAIL reset_values got %h %h %h exp 0", mepc, mcause, redirectPc);
      end
      rstN = 1'b1;
      @(negedge clk);
      checkCount++;
      if (trapReady !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL reset_ready got %b exp 1", trapReady);
      end
   endtask

   task automatic test_trap_cases;
      exp_t e;
      int   waitCnt;
      redirectReady = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         checkCount++;
         if (trapReady !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL case%0d_ready got %b exp 1", i, trapReady);
         end
         applyStimulus(caseMode[i], caseBase[i], caseIntr[i], caseCause[i], casePc[i],
                       caseMepc[i], caseMcause[i], caseTarget[i]);
         @(negedge clk);
         // Scramble the trap inputs to prove the accepted values were held.
         trapValid     = 1'b0;
         mtvecMode     = 2'd1;
         mtvecBase     = 30'($urandom);
         trapInterrupt = 1'b1;
         trapCause     = 5'h1F;
         trapPc        = $urandom;
         waitCnt = 0;
         while (csrWrite !== 1'b1 && waitCnt < 8) begin
            @(negedge clk);
            waitCnt++;
         end
         checkCount++;
         if (waitCnt != 0 || expQ.size() == 0) begin
            errorCount++;
            $display("[TB] FAIL case%0d_csr_latency got %0d exp 0", i, waitCnt);
         end else begin
            e = expQ.pop_front();
            checkCount++;
            if (mepc !== e.mepc || mcause !== e.mcause) begin
               errorCount++;
               $display("[TB] FAIL case%0d_csr got %h %h exp %h %h", i, mepc, mcause,
                        e.mepc, e.mcause);
            end
            checkCount++;
            if (redirectPc !== e.target || redirectValid !== 1'b0 || trapReady !== 1'b0) begin
               errorCount++;
               $display("[TB] FAIL case%0d_entry got pc %h v %b r %b exp pc %h v 0 r 0", i,
                        redirectPc, redirectValid, trapReady, e.target);
            end
            @(negedge clk);
            checkCount++;
            if (redirectValid !== 1'b1 || csrWrite !== 1'b0 || redirectPc !== e.target) begin
               errorCount++;
               $display("[TB] FAIL case%0d_redirect got v %b w %b pc %h exp v 1 w 0 pc %h", i,
                        redirectValid, csrWrite, redirectPc, e.target);
            end
            @(negedge clk);
            checkCount++;
            if (redirectValid !== 1'b0 || busy !== 1'b0 || trapReady !== 1'b1) begin
               errorCount++;
               $display("[TB] FAIL case%0d_idle got v %b b %b r %b exp 0 0 1", i,
                        redirectValid, busy, trapReady);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      exp_t e;
      @(negedge clk);
      redirectReady = 1'b0;
      applyStimulus(2'd0, 30'h100, 1'b0, 5'd3, 32'h8000_0044,
                    32'h8000_0044, 32'h0000_0003, 32'h0000_0400);
      @(negedge clk);
      trapValid = 1'b0;
      checkCount++;
      if (csrWrite !== 1'b1 || expQ.size() == 0) begin
         errorCount++;
         $display("[TB] FAIL bp_csr got %b exp 1", csrWrite);
      end else begin
         e = expQ.pop_front();
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkCount++;
            if (redirectValid !== 1'b1 || redirectPc !== e.target || trapReady !== 1'b0 ||
                busy !== 1'b1 || csrWrite !== 1'b0 || mepc !== e.mepc || mcause !== e.mcause) begin
               errorCount++;
               $display("[TB] FAIL bp_hold%0d got v %b pc %h r %b b %b w %b mepc %h exp v 1 pc %h r 0 b 1 w 0 mepc %h",
                        c, redirectValid, redirectPc, trapReady, busy, csrWrite, mepc,
                        e.target, e.mepc);
            end
            mtvecMode     = 2'd1;
            mtvecBase     = 30'($urandom);
            trapInterrupt = 1'b1;
            trapPc        = 32'h1234_5678;
            trapValid     = (c % 2 == 0);
         end
         @(negedge clk);
         trapValid     = 1'b0;
         redirectReady = 1'b1;
         @(negedge clk);
         checkCount++;
         if (redirectValid !== 1'b0 || busy !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL bp_release got v %b b %b exp 0 0", redirectValid, busy);
         end
         @(negedge clk);
         checkCount++;
         if (csrWrite !== 1'b0 || mepc !== e.mepc) begin
            errorCount++;
            $display("[TB] FAIL bp_no_second got w %b mepc %h exp 0 %h", csrWrite, mepc, e.mepc);
         end
      end
   endtask

   task automatic test_reset_mid_redirect;
      int waitCnt;
      exp_t e;
      @(negedge clk);
      redirectReady = 1'b0;
      applyStimulus(2'd1, 30'h200, 1'b1, 5'd3, 32'h0000_1000,
                    32'h0000_1000, 32'h8000_0003, 32'h0000_080C);
      @(negedge clk);
      trapValid = 1'b0;
      void'(expQ.pop_front());
      @(negedge clk);
      checkCount++;
      if (redirectValid !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL rst_pre_valid got %b exp 1", redirectValid);
      end
      rstN = 1'b0;
      #1;
      checkCount++;
      if (redirectValid !== 1'b0 || busy !== 1'b0 || redirectPc !== 32'd0 || mepc !== 32'd0) begin
         errorCount++;
         $display("[TB] FAIL rst_async got v %b b %b pc %h mepc %h exp 0 0 0 0",
                  redirectValid, busy, redirectPc, mepc);
      end
      @(negedge clk);
      rstN          = 1'b1;
      redirectReady = 1'b1;
      @(negedge clk);
      applyStimulus(2'd1, 30'h100, 1'b1, 5'd7, 32'h8000_0040,
                    32'h8000_0040, 32'h8000_0007, 32'h0000_041C);
      @(negedge clk);
      trapValid = 1'b0;
      waitCnt = 0;
      while (csrWrite !== 1'b1 && waitCnt < 8) begin
         @(negedge clk);
         waitCnt++;
      end
      checkCount++;
      if (csrWrite !== 1'b1 || expQ.size() == 0) begin
         errorCount++;
         $display("[TB] FAIL rst_after_trap got w %b exp 1", csrWrite);
      end else begin
         e = expQ.pop_front();
         checkCount++;
         if (mcause !== e.mcause || redirectPc !== e.target) begin
            errorCount++;
            $display("[TB] FAIL rst_after_values got %h %h exp %h %h", mcause, redirectPc,
                     e.mcause, e.target);
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   gap;
      int   waitCnt;
      @(negedge clk);
      redirectReady = 1'b1;
      applyStimulus(2'd0, 30'h40, 1'b0, 5'd4, 32'h0000_2000,
                    32'h0000_2000, 32'h0000_0004, 32'h0000_0100);
      @(negedge clk);
      checkCount++;
      if (csrWrite !== 1'b1 || expQ.size() == 0) begin
         errorCount++;
         $display("[TB] FAIL b2b_first got w %b exp 1", csrWrite);
      end else begin
         e = expQ.pop_front();
         checkCount++;
         if (mepc !== e.mepc || redirectPc !== e.target) begin
            errorCount++;
            $display("[TB] FAIL b2b_first_values got %h %h exp %h %h", mepc, redirectPc,
                     e.mepc, e.target);
         end
         // Source keeps valid high; the second trap is taken once IDLE returns.
         applyStimulus(2'd1, 30'h40, 1'b1, 5'd2, 32'h0000_3008,
                       32'h0000_3008, 32'h8000_0002, 32'h0000_0108);
         gap = 0;
         waitCnt = 0;
         do begin
            @(negedge clk);
            gap++;
            waitCnt++;
         end while (csrWrite !== 1'b1 && waitCnt < 10);
         trapValid = 1'b0;
         checkCount++;
         if (gap != 3 || expQ.size() == 0) begin
            errorCount++;
            $display("[TB] FAIL b2b_spacing got %0d exp 3", gap);
         end else begin
            e = expQ.pop_front();
            checkCount++;
            if (mepc !== e.mepc || mcause !== e.mcause || redirectPc !== e.target) begin
               errorCount++;
               $display("[TB] FAIL b2b_second got %h %h %h exp %h %h %h", mepc, mcause,
                        redirectPc, e.mepc, e.mcause, e.target);
            end
         end
      end
      repeat (3) @(negedge clk);
   endtask

`ifdef RISCV_TRAP_REDIRECT_MRET_EN
   task automatic test_mret;
      @(negedge clk);
      redirectReady = 1'b0;
      mretValid     = 1'b1;
      mepcIn        = 32'h8000_1236;
      @(negedge clk);
      mretValid = 1'b0;
      checkCount++;
      if (csrWrite !== 1'b0 || redirectValid !== 1'b1 || redirectPc !== 32'h8000_1234) begin
         errorCount++;
         $display("[TB] FAIL mret_redirect got w %b v %b pc %h exp 0 1 80001234",
                  csrWrite, redirectValid, redirectPc);
      end
      redirectReady = 1'b1;
      @(negedge clk);
      @(negedge clk);
      mretValid = 1'b1;
      applyStimulus(2'd0, 30'h100, 1'b0, 5'd2, 32'h8000_0040,
                    32'h8000_0040, 32'h0000_0002, 32'h0000_0400);
      @(negedge clk);
      mretValid = 1'b0;
      trapValid = 1'b0;
      checkCount++;
      if (csrWrite !== 1'b1 || redirectPc !== 32'h0000_0400) begin
         errorCount++;
         $display("[TB] FAIL mret_trap_priority got w %b pc %h exp 1 00000400",
                  csrWrite, redirectPc);
      end
      if (expQ.size() != 0) void'(expQ.pop_front());
      repeat (3) @(negedge clk);
   endtask
`endif

   initial begin
      test_reset;
      test_trap_cases;
      test_backpressure;
      test_reset_mid_redirect;
      test_back_to_back;
`ifdef RISCV_TRAP_REDIRECT_MRET_EN
      test_mret;
`endif
      checkCount++;
      if (expQ.size() != 0) begin
         errorCount++;
         $display("[TB] FAIL scoreboard_left got %0d exp 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
